// File: rtl/adder_arbiter_pkg.sv
// Shared constants and helpers for the adder arbiter slice.
//   NUM_SIZE_DEF : default operand/sum width
//   id_width()   : requester-tag width, max(1, clog2(n))
//   REQ_*        : RV32I requester index assignments
package adder_arbiter_pkg;

    localparam int NUM_SIZE_DEF = 32;

    // RV32I requester slots on the shared adder
    localparam int REQ_PC  = 0;
    localparam int REQ_BR  = 1;
    localparam int REQ_ALU = 2;

    // A single requester still needs a 1-bit tag, so clamp at 1.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adder.sv
// Signed two's-complement adder datapath, no carry-in.
//   dIn0, dIn1 : operands
//   sum        : dIn0 + dIn1 modulo 2^NUM_SIZE
//   overflow   : signed overflow of that addition
module adder #(
    parameter int NUM_SIZE = 32
) (
    input  logic [NUM_SIZE-1:0] dIn0,
    input  logic [NUM_SIZE-1:0] dIn1,
    output logic [NUM_SIZE-1:0] sum,
    output logic                overflow
);

    assign sum = dIn0 + dIn1;

    // Overflow only when both operands share a sign and the result flips it.
    assign overflow = (dIn0[NUM_SIZE-1] == dIn1[NUM_SIZE-1]) &&
                      (sum[NUM_SIZE-1] != dIn0[NUM_SIZE-1]);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req      : request vector
//   rrPtr    : index searched first; search wraps modulo NUM_REQ
//   en       : when low no grant is issued
//   grant    : one-hot grant (all zero if none)
//   grantId  : encoded index of the granted requester (0 if none)
module rr_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 3,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rrPtr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grantId
);

    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        grant   = '0;
        grantId = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(rrPtr) + k) % NUM_REQ);
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grantId    = idx;
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one signed adder between NUM_REQ requesters with round-robin
// arbitration and a single registered, ID-tagged response channel.
//   clk, rst          : clock, synchronous active-high reset
//   reqValid/reqReady : per-requester handshake (reqReady combinational)
//   reqA, reqB        : packed operands, requester i at [i*NUM_SIZE +: NUM_SIZE]
//   respValid/Ready   : response handshake
//   respId, respSum, respOverflow : registered result and owner tag
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter  int NUM_SIZE = NUM_SIZE_DEF,
    parameter  int NUM_REQ  = 3,
    localparam int ID_W     = id_width(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          reqValid,
    input  logic [NUM_REQ*NUM_SIZE-1:0] reqA,
    input  logic [NUM_REQ*NUM_SIZE-1:0] reqB,
    output logic [NUM_REQ-1:0]          reqReady,
    output logic                        respValid,
    input  logic                        respReady,
    output logic [ID_W-1:0]             respId,
    output logic [NUM_SIZE-1:0]         respSum,
    output logic                        respOverflow
);

    logic [NUM_SIZE-1:0] a_arr [NUM_REQ];
    logic [NUM_SIZE-1:0] b_arr [NUM_REQ];
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_id;
    logic [ID_W-1:0]     rrPtr;
    logic [NUM_SIZE-1:0] op_a;
    logic [NUM_SIZE-1:0] op_b;
    logic [NUM_SIZE-1:0] add_sum;
    logic                add_ovf;
    logic                can_accept;
    logic                accept;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = reqA[gi*NUM_SIZE +: NUM_SIZE];
            assign b_arr[gi] = reqB[gi*NUM_SIZE +: NUM_SIZE];
        end
    endgenerate

    // The response slot frees up in the same cycle it is drained, which
    // is what gives back-to-back throughput.
    assign can_accept = ~respValid | respReady;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req     (reqValid),
        .rrPtr   (rrPtr),
        .en      (can_accept & ~rst),
        .grant   (grant),
        .grantId (grant_id)
    );

    assign reqReady = grant;
    assign accept   = |grant;

    // One-hot AND-OR mux; defaults to zero when nothing is granted so the
    // adder inputs never carry X.
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                op_a = op_a | a_arr[k];
                op_b = op_b | b_arr[k];
            end
        end
    end

    adder #(
        .NUM_SIZE (NUM_SIZE)
    ) u_adder (
        .dIn0     (op_a),
        .dIn1     (op_b),
        .sum      (add_sum),
        .overflow (add_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            respValid    <= 1'b0;
            respSum      <= '0;
            respOverflow <= 1'b0;
            respId       <= '0;
            rrPtr        <= '0;
        end else if (accept) begin
            respValid    <= 1'b1;
            respSum      <= add_sum;
            respOverflow <= add_ovf;
            respId       <= grant_id;
            rrPtr        <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end else if (respValid && respReady) begin
            respValid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;
    import adder_arbiter_pkg::*;

    localparam int NS = 32;
    localparam int NR = 3;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   reqValid;
    logic [NR*NS-1:0] reqA;
    logic [NR*NS-1:0] reqB;
    logic [NR-1:0]   reqReady;
    logic            respValid;
    logic            respReady;
    logic [IW-1:0]   respId;
    logic [NS-1:0]   respSum;
    logic            respOverflow;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adder_arbiter #(.NUM_SIZE(NS), .NUM_REQ(NR)) dut (
        .clk          (clk),
        .rst          (rst),
        .reqValid     (reqValid),
        .reqA         (reqA),
        .reqB         (reqB),
        .reqReady     (reqReady),
        .respValid    (respValid),
        .respReady    (respReady),
        .respId       (respId),
        .respSum      (respSum),
        .respOverflow (respOverflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [NS-1:0] a, input logic [NS-1:0] b);
        reqA[i*NS +: NS] = a;
        reqB[i*NS +: NS] = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_resp(input string tag, input logic v, input logic [IW-1:0] id,
                            input logic [NS-1:0] s, input logic o);
        chk({tag, ".valid"}, 64'(respValid), 64'(v));
        chk({tag, ".id"}, 64'(respId), 64'(id));
        chk({tag, ".sum"}, 64'(respSum), 64'(s));
        chk({tag, ".ovf"}, 64'(respOverflow), 64'(o));
        $display("txn %s: valid=%0b id=%0d sum=%08h ovf=%0b", tag, respValid, respId, respSum, respOverflow);
    endtask

    initial begin
        int exp_id;
        rst       = 1'b1;
        reqValid  = 3'b111;
        respReady = 1'b0;
        reqA      = '0;
        reqB      = '0;
        set_op(0, 32'd11, 32'd22);

        // Reset held two cycles with all requests asserted
        tick();
        chk("rst.ready_c1", 64'(reqReady), 64'd0);
        tick();
        chk("rst.ready_c2", 64'(reqReady), 64'd0);
        chk_resp("rst", 1'b0, 2'd0, 32'd0, 1'b0);

        // First cycle after release: requester 0 wins from rrPtr=0
        rst = 1'b0;
        #1;
        chk("post_rst.ready", 64'(reqReady), 64'b001);
        reqValid = 3'b000;
        tick();
        chk("idle.valid", 64'(respValid), 64'd0);

        // Single add on the branch requester: 7 + -3
        reqValid = 3'b000;
        reqValid[REQ_BR] = 1'b1;
        set_op(REQ_BR, 32'd7, 32'hFFFF_FFFD);
        #1;
        chk("single.ready", 64'(reqReady), 64'b010);
        tick();
        reqValid = 3'b000;
        chk_resp("single", 1'b1, 2'd1, 32'd4, 1'b0);

        // Overflow cases on requester 0 only (rrPtr=2, still granted)
        respReady = 1'b1;
        reqValid  = 3'b001;
        set_op(0, 32'h7FFF_FFFF, 32'h0000_0001);
        #1;
        chk("ovf1.ready", 64'(reqReady), 64'b001);
        tick();
        chk_resp("ovf_pos", 1'b1, 2'd0, 32'h8000_0000, 1'b1);
        set_op(0, 32'h8000_0000, 32'h8000_0000);
        tick();
        chk_resp("ovf_neg", 1'b1, 2'd0, 32'h0000_0000, 1'b1);
        set_op(0, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
        tick();
        chk_resp("mixed_sign", 1'b1, 2'd0, 32'h7FFF_FFFE, 1'b0);
        set_op(0, 32'hFFFF_FFFB, 32'h0000_0003);
        tick();
        chk_resp("neg_small", 1'b1, 2'd0, 32'hFFFF_FFFE, 1'b0);

        // Requester 2 alone while rrPtr=1: granted, rrPtr wraps to 0
        reqValid = 3'b100;
        set_op(2, 32'd5, 32'd6);
        #1;
        chk("solo2.ready", 64'(reqReady), 64'b100);
        tick();
        chk_resp("solo2", 1'b1, 2'd2, 32'd11, 1'b0);

        // Fairness: all three held, expect 0,1,2,0,1,2
        for (int i = 0; i < NR; i++) set_op(i, 32'(100 * (i + 1)), 32'(i));
        reqValid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            exp_id = c % NR;
            #1;
            chk("fair.ready", 64'(reqReady), 64'(1 << exp_id));
            tick();
            chk_resp("fair", 1'b1, IW'(exp_id), 32'(100 * (exp_id + 1) + exp_id), 1'b0);
        end

        // Backpressure: response (id2, 302) held while req2 waits
        respReady = 1'b0;
        reqValid  = 3'b100;
        set_op(2, 32'd1000, 32'd24);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp.ready", 64'(reqReady), 64'd0);
            tick();
            chk_resp("bp_hold", 1'b1, 2'd2, 32'd302, 1'b0);
        end
        respReady = 1'b1;
        #1;
        chk("bp_release.ready", 64'(reqReady), 64'b100);
        tick();
        chk_resp("bp_reload", 1'b1, 2'd2, 32'd1024, 1'b0);

        // Drain with nothing pending: valid drops, data holds
        reqValid = 3'b000;
        tick();
        chk_resp("drain", 1'b0, 2'd2, 32'd1024, 1'b0);

        // Reset mid-stream: load id1 (rrPtr -> 2), then reset with requests pending
        respReady = 1'b0;
        reqValid  = 3'b010;
        set_op(1, 32'd40, 32'd2);
        tick();
        chk_resp("pre_rst", 1'b1, 2'd1, 32'd42, 1'b0);
        rst       = 1'b1;
        respReady = 1'b1;
        reqValid  = 3'b111;
        #1;
        chk("mid_rst.ready", 64'(reqReady), 64'd0);
        tick();
        chk_resp("mid_rst", 1'b0, 2'd0, 32'd0, 1'b0);
        rst = 1'b0;
        #1;
        chk("after_rst.ready", 64'(reqReady), 64'b001);
        tick();
        chk_resp("after_rst", 1'b1, 2'd0, 32'd100, 1'b0);

        reqValid = 3'b000;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Shares one NUM_SIZE-bit signed adder, the existing `adder.v` datapath with ports dIn0/dIn1/sum/overflow, between NUM_REQ requesters.

- Requesters are, for example, PC+4, branch target and ALU add.
- Arbitration is round-robin over per-requester valid/ready request channels.
- Each result is returned on one registered response channel, tagged with the requester ID.
- The block sits between the RV32I front-end/execute units and the single physical adder.

## Interface
Parameters:
- NUM_SIZE, 32, operand and sum width in bits.
- NUM_REQ, 3, number of requesters (2..8).
- ID_W, derived as max(1, clog2(NUM_REQ)), width of the requester tag. This is a localparam, not overridable.

Ports:
- clk  in  1  single clock; every register updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- reqValid  in  NUM_REQ  bit i: requester i presents operands.
- reqA  in  NUM_REQ*NUM_SIZE  operand A of requester i at [i*NUM_SIZE +: NUM_SIZE], signed.
- reqB  in  NUM_REQ*NUM_SIZE  operand B of requester i, same slicing, signed.
- reqReady  out  NUM_REQ  bit i: requester i's operands are taken this cycle. Combinational. At most one bit is high.
- respValid  out  1  response register holds a result.
- respReady  in  1  consumer takes the result this cycle.
- respId  out  ID_W  index of the requester that owns the result.
- respSum  out  NUM_SIZE  registered sum, wraps modulo 2^NUM_SIZE.
- respOverflow  out  1  registered signed overflow of that addition.

## Operation
Round-robin pointer `rrPtr` (ID_W bits):
- Grant goes to the first i with reqValid[i]=1, searching rrPtr, rrPtr+1, … modulo NUM_REQ.

Definitions:
- canAccept = ~respValid | respReady.
- reqReady[i] = grant[i] & canAccept.
- accept = |reqReady.

When accept=1, in the same cycle:
- The granted operands drive dIn0/dIn1 of the adder instance.
- On the clock edge the following are loaded: respSum ← sum, respOverflow ← overflow, respId ← granted index, respValid ← 1.
- rrPtr ← (granted index + 1) mod NUM_REQ.

When accept=0:
- If respReady & respValid, then respValid ← 0. respSum, respId and respOverflow hold their last values.
- rrPtr holds.

Operand muxing when nothing is granted:
- dIn0/dIn1 are driven with 0. This is don't-care functionally, but must not be X.

Arithmetic:
- Two's-complement, NUM_SIZE bits, no carry-in.
- overflow = (A[msb]==B[msb]) & (sum[msb]!=A[msb]).
- Overflow is computed by the adder instance and must match this definition.

Boundary conditions:
- Full response register with respReady=0: all reqReady=0, registers hold, rrPtr holds.
- Full register with respReady=1 and a pending request: drain and reload happen in the same cycle, giving back-to-back throughput of 1 result per cycle.
- Only one requester active: it is granted every cycle regardless of rrPtr.
- A requester may drop reqValid without being granted. No state is retained for it.
- rrPtr wraps from NUM_REQ-1 to 0. Values ≥ NUM_REQ are never produced.

Reset (rst=1 at an edge) overrides everything, including a transfer in progress:
- respValid=0, respSum=0, respOverflow=0, respId=0, rrPtr=0.
- reqReady is low throughout reset, because the arbiter is gated by rst.

## Timing
- Request→response latency is 1 cycle. A request accepted at edge N (reqValid&reqReady high in the cycle before edge N) gives respValid=1 with the result from edge N onward.
- Throughput is 1 accept per cycle while respReady=1.
- reqReady depends combinationally on reqValid, respValid, respReady, rrPtr and rst.
- Response outputs are registered only.
- The adder path is combinational within the accept cycle, so the critical path is mux + NUM_SIZE-bit add + response register.
- First accept possible in the cycle after rst deasserts.

## Structure
Shared defines header (`adder_defs.vh`):
- NUM_SIZE default (32).
- The clog2-based ID width function.
- RV32I requester index constants: REQ_PC=0, REQ_BR=1, REQ_ALU=2.

Sub-module `rr_arbiter`:
- Parameter NUM_REQ.
- Inputs: req, rrPtr, en.
- Output: one-hot grant plus encoded index.
- Purely combinational. rrPtr stays inside adder_arbiter.

Adder: instantiate the existing adder module unchanged.

## Test plan
- Reset: hold rst 2 cycles with reqValid=3'b111 → reqReady=0, respValid=0, respSum=0, respId=0. First cycle after release, req0 granted (rrPtr=0).
- Single add: req1 A=7, B=-3 → respValid next cycle, respSum=4, respId=1, respOverflow=0.
- Overflow: req0 A=0x7FFFFFFF, B=1 → respSum=0x80000000, respOverflow=1. Also req0 A=0x80000000, B=0x80000000 → respSum=0, respOverflow=1.
- Fairness: all three reqValid held high, respReady=1 for 6 cycles → respId sequence 0,1,2,0,1,2, one result per cycle.
- Backpressure: respValid=1 with respReady=0 for 3 cycles while req2 is valid → reqReady stays 0 and the response holds stable. Raising respReady drains and accepts req2 in the same cycle; next cycle respId=2.
- Reset mid-stream: assert rst while respValid=1 and requests pending → next cycle respValid=0 and rrPtr=0. After release, req0 is granted first.
